// File: rtl/snn_run_sequencer.sv
// snn_run_sequencer
//   Runs a batch of back-to-back SNN inferences. Each sample goes through these steps:
//     1. One CLEAR cycle that pulses net_rst.
//     2. sim_time timesteps of SPIKE_PERIOD cycles each. Each timestep opens with a spike_en strobe.
//     3. A settle window of SETTLE_CYCLES cycles.
//     4. NUM_OUTPUTS store cycles that write the saturating per-output spike counts into the
//        output-count RAM.
//   Optional feature macro: SNN_SEQ_WINNER_EN. When it is defined, the block reports the argmax
//   output of each sample.
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start, i_abort      run control (abort wins; start only accepted in idle)
//   i_sim_time            timesteps per sample, latched on start
//   i_num_samples         samples per run (0 means 1), latched on start
//   i_spike_out           output spikes, counted in RUN/SETTLE cycles
//   o_net_rst             1-cycle network reset (each sample, and after abort)
//   o_spike_en            timestep strobe
//   o_timestep            timestep index within the sample
//   o_sample_idx          current sample index
//   o_cnt_wr_*            count RAM write port
//   o_busy, o_done        run status (done is a level)
//   o_winner_idx/_valid   argmax of last sample (zero unless SNN_SEQ_WINNER_EN)
module snn_run_sequencer #(
  parameter int unsigned NUM_OUTPUTS   = 4,
  parameter int unsigned COUNT_WIDTH   = 16,
  parameter int unsigned TIMESTEP_BITS = 8,
  parameter int unsigned SAMPLE_BITS   = 6,
  parameter int unsigned ADDR_BITS     = 10,
  parameter int unsigned SPIKE_PERIOD  = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned IDX_W        = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [TIMESTEP_BITS-1:0] i_sim_time,
  input  logic [SAMPLE_BITS-1:0]   i_num_samples,
  input  logic [NUM_OUTPUTS-1:0]   i_spike_out,
  output logic                     o_net_rst,
  output logic                     o_spike_en,
  output logic [TIMESTEP_BITS-1:0] o_timestep,
  output logic [SAMPLE_BITS-1:0]   o_sample_idx,
  output logic                     o_cnt_wr_en,
  output logic [ADDR_BITS-1:0]     o_cnt_wr_addr,
  output logic [COUNT_WIDTH-1:0]   o_cnt_wr_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [IDX_W-1:0]         o_winner_idx,
  output logic                     o_winner_valid
);

  localparam int unsigned PH_W  = (SPIKE_PERIOD > 1) ? $clog2(SPIKE_PERIOD) : 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [COUNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic [2:0] {StIdle, StClear, StRun, StSettle, StStore, StDone} state_e;

  state_e                   r_state, w_next;
  logic [TIMESTEP_BITS-1:0] r_sim_time, r_timestep;
  logic [SAMPLE_BITS-1:0]   r_last_sample, r_sample_idx;
  logic [ADDR_BITS-1:0]     r_base;
  logic [PH_W-1:0]          r_phase;
  logic [SET_W-1:0]         r_settle_cnt;
  logic [IDX_W-1:0]         r_store_k;
  logic                     r_last_ts, r_done, r_abort_q;
  logic [COUNT_WIDTH-1:0]   r_counts [NUM_OUTPUTS];

  logic w_abort, w_start, w_strobe, w_last_strobe, w_run_done, w_settle_done;
  logic w_store_last, w_last_sample;

  assign w_abort       = i_abort && (r_state != StIdle);
  assign w_start       = i_start && !i_abort && (r_state == StIdle);
  assign w_strobe      = (r_state == StRun) && (r_phase == '0);
  assign w_last_strobe = w_strobe && (r_timestep == r_sim_time - TIMESTEP_BITS'(1));
  // r_last_ts covers periods longer than one cycle, where the final strobe is already past.
  assign w_run_done    = (r_phase == PH_W'(SPIKE_PERIOD - 1)) && (r_last_ts || w_last_strobe);
  assign w_settle_done = (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1));
  assign w_store_last  = (r_store_k == IDX_W'(NUM_OUTPUTS - 1));
  assign w_last_sample = (r_sample_idx == r_last_sample);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StIdle:   if (w_start) w_next = StClear;
      StClear: begin
        if (r_sim_time != '0)        w_next = StRun;
        else if (SETTLE_CYCLES != 0) w_next = StSettle;
        else                         w_next = StStore;
      end
      StRun: begin
        if (w_run_done) begin
          if (SETTLE_CYCLES != 0) w_next = StSettle;
          else                    w_next = StStore;
        end
      end
      StSettle: if (w_settle_done) w_next = StStore;
      StStore: begin
        if (w_store_last) begin
          if (w_last_sample) w_next = StDone;
          else               w_next = StClear;
        end
      end
      StDone:   w_next = StIdle;
      default:  w_next = StIdle;
    endcase
    if (w_abort) w_next = StIdle;
  end

  // Sequencing datapath
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sim_time    <= '0;
      r_last_sample <= '0;
      r_timestep    <= '0;
      r_sample_idx  <= '0;
      r_base        <= '0;
      r_phase       <= '0;
      r_settle_cnt  <= '0;
      r_store_k     <= '0;
      r_last_ts     <= 1'b0;
      r_done        <= 1'b0;
      r_abort_q     <= 1'b0;
    end else begin
      r_abort_q <= w_abort;
      if (w_abort) begin
        r_done       <= 1'b0;
        r_timestep   <= '0;
        r_sample_idx <= '0;
        r_base       <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_start) begin
              r_sim_time    <= i_sim_time;
              r_last_sample <= (i_num_samples == '0) ? '0
                                                     : i_num_samples - SAMPLE_BITS'(1);
              r_done        <= 1'b0;
              r_sample_idx  <= '0;
              r_base        <= '0;
            end
          end
          StClear: begin
            r_timestep   <= '0;
            r_phase      <= '0;
            r_settle_cnt <= '0;
            r_store_k    <= '0;
            r_last_ts    <= 1'b0;
          end
          StRun: begin
            r_phase <= (r_phase == PH_W'(SPIKE_PERIOD - 1)) ? '0 : r_phase + PH_W'(1);
            if (w_strobe)      r_timestep <= r_timestep + TIMESTEP_BITS'(1);
            if (w_last_strobe) r_last_ts  <= 1'b1;
          end
          StSettle: r_settle_cnt <= r_settle_cnt + SET_W'(1);
          StStore: begin
            r_store_k <= r_store_k + IDX_W'(1);
            if (w_store_last) begin
              if (w_last_sample) begin
                r_done <= 1'b1;
              end else begin
                r_sample_idx <= r_sample_idx + SAMPLE_BITS'(1);
                r_base       <= r_base + ADDR_BITS'(NUM_OUTPUTS);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating per-output spike counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) r_counts[i] <= '0;
    end else if (r_state == StClear) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) r_counts[i] <= '0;
    end else if (r_state == StRun || r_state == StSettle) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (i_spike_out[i] && (r_counts[i] != CntMax)) r_counts[i] <= r_counts[i] + COUNT_WIDTH'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    o_net_rst     = (r_state == StClear) || r_abort_q;
    o_spike_en    = w_strobe;
    o_timestep    = r_timestep;
    o_sample_idx  = r_sample_idx;
    o_cnt_wr_en   = (r_state == StStore) && !w_abort;
    o_cnt_wr_addr = r_base + ADDR_BITS'(r_store_k);
    o_cnt_wr_data = r_counts[r_store_k];
    o_busy        = (r_state != StIdle) && (r_state != StDone);
    o_done        = r_done;
  end

`ifdef SNN_SEQ_WINNER_EN
  logic [COUNT_WIDTH-1:0] r_win_max, w_cand_max;
  logic [IDX_W-1:0]       r_win_idx, w_cand_idx, r_winner_idx;
  logic                   r_winner_valid;

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    w_cand_max = r_win_max;
    w_cand_idx = r_win_idx;
    if (r_store_k == '0 || r_counts[r_store_k] > r_win_max) begin
      w_cand_max = r_counts[r_store_k];
      w_cand_idx = r_store_k;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_win_max      <= '0;
      r_win_idx      <= '0;
      r_winner_idx   <= '0;
      r_winner_valid <= 1'b0;
    end else begin
      r_winner_valid <= 1'b0;
      if (r_state == StStore && !w_abort) begin
        r_win_max <= w_cand_max;
        r_win_idx <= w_cand_idx;
        if (w_store_last) begin
          r_winner_idx   <= w_cand_idx;
          r_winner_valid <= 1'b1;
        end
      end
    end
  end

  assign o_winner_idx   = r_winner_idx;
  assign o_winner_valid = r_winner_valid;
`else
  assign o_winner_idx   = '0;
  assign o_winner_valid = 1'b0;
`endif

endmodule
